// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction-fetch memory slice.
//   AW        : default fetch/load address width (matches the PC width)
//   IW        : default instruction width
//   NOP_INSTR : word driven on the instruction output whenever no fetch
//               result is being presented
//   state_t   : fetch responder states (LOAD, RUN, HALTED)
// ---------------------------------------------------------------------------
package fetch_pkg;

    localparam int AW = 10;
    localparam int IW = 9;

    localparam logic [IW-1:0] NOP_INSTR = '0;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

endpackage

// File: rtl/imem_ram.sv
// ---------------------------------------------------------------------------
// imem_ram
// DEPTH x IW single-write / single-read synchronous RAM with registered read
// data. Addresses at or beyond DEPTH are ignored on both ports.
// Ports:
//   clk   : clock, write and read register update on posedge
//   we    : write enable
//   waddr : write address (AW bits)
//   wdata : write data (IW bits)
//   re    : read enable; read register holds its value when low
//   raddr : read address (AW bits)
//   rdata : registered read data, valid the cycle after re
// ---------------------------------------------------------------------------
module imem_ram #(
    parameter int AW    = 10,
    parameter int IW    = 9,
    parameter int DEPTH = 1024
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [IW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [IW-1:0] rdata
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [IW-1:0] mem [DEPTH];
    logic [IW-1:0] rdata_q;
    logic [IW-1:0] rdata_d;
    logic          wr_ok;
    logic          rd_ok;

    // The full address is compared against DEPTH so that high address bits
    // never alias onto a smaller array.
    assign wr_ok = we && (int'(waddr) < DEPTH);
    assign rd_ok = re && (int'(raddr) < DEPTH);

    // Storage array; no reset so contents survive a reset of the fetch FSM.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[waddr[IDX_W-1:0]] <= wdata;
        end
    end

    // Next read data: hold the last word unless a valid read is requested.
    always_comb begin
        rdata_d = rdata_q;
        if (rd_ok) begin
            rdata_d = mem[raddr[IDX_W-1:0]];
        end
    end

    // Read data register gives the one-cycle fetch latency.
    always_ff @(posedge clk) begin
        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/instr_fetch_mem.sv
// ---------------------------------------------------------------------------
// instr_fetch_mem
// Instruction-memory responder facing the program counter. Words are loaded
// through a write-only port, then each PC presented in RUN is answered one
// cycle later. Tracks halt, flags out-of-range fetches and PC discontinuities,
// and counts valid fetches.
// Ports:
//   CLK         : clock, all state updates on posedge
//   init        : asynchronous active-high reset
//   load_en     : load write strobe (honoured only in LOAD)
//   load_addr   : load write address
//   load_data   : load write data
//   load_done   : ends the load phase
//   PC          : fetch address
//   halt        : halt request from the program counter
//   instruction : fetched word for the previous cycle's PC
//   instr_valid : instruction holds a fetch result
//   redirect    : previous fetch PC was not the successor of the one before
//   addr_err    : one-cycle pulse for a fetch PC >= DEPTH
//   running     : high while in RUN
//   fetch_count : saturating count of valid in-range fetches
// ---------------------------------------------------------------------------
module instr_fetch_mem #(
    parameter int AW    = fetch_pkg::AW,
    parameter int IW    = fetch_pkg::IW,
    parameter int DEPTH = 1024,
    parameter int CW    = 16
) (
    input  logic          CLK,
    input  logic          init,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [IW-1:0] load_data,
    input  logic          load_done,
    input  logic [AW-1:0] PC,
    input  logic          halt,
    output logic [IW-1:0] instruction,
    output logic          instr_valid,
    output logic          redirect,
    output logic          addr_err,
    output logic          running,
    output logic [CW-1:0] fetch_count
);

    import fetch_pkg::*;

    localparam logic [CW-1:0] COUNT_MAX = '1;

    state_t        state_q, state_d;
    logic          valid_q, valid_d;
    logic          redirect_q, redirect_d;
    logic          addr_err_q, addr_err_d;
    logic          running_q, running_d;
    logic          hit_q, hit_d;
    logic          first_q, first_d;
    logic [AW-1:0] last_pc_q, last_pc_d;
    logic [CW-1:0] fetch_count_q, fetch_count_d;

    logic          ram_we;
    logic          ram_re;
    logic [IW-1:0] ram_rdata;
    logic          pc_in_range;
    logic [AW-1:0] seq_pc;

    assign pc_in_range = int'(PC) < DEPTH;
    // Successor wraps modulo 2**AW by virtue of the AW-bit add.
    assign seq_pc      = last_pc_q + AW'(1);

    imem_ram #(
        .AW    (AW),
        .IW    (IW),
        .DEPTH (DEPTH)
    ) u_imem_ram (
        .clk   (CLK),
        .we    (ram_we),
        .waddr (load_addr),
        .wdata (load_data),
        .re    (ram_re),
        .raddr (PC),
        .rdata (ram_rdata)
    );

    // Next-state and fetch bookkeeping. Every flag output defaults to 0 so
    // LOAD, HALTED and the halt cycle all present an idle fetch interface;
    // PC history and the counter default to holding.
    always_comb begin
        state_d       = state_q;
        valid_d       = 1'b0;
        redirect_d    = 1'b0;
        addr_err_d    = 1'b0;
        hit_d         = 1'b0;
        first_d       = first_q;
        last_pc_d     = last_pc_q;
        fetch_count_d = fetch_count_q;
        ram_we        = 1'b0;
        ram_re        = 1'b0;

        case (state_q)
            LOAD: begin
                ram_we = load_en;
                if (load_done) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                // halt wins over everything, including an out-of-range PC.
                if (halt) begin
                    state_d = HALTED;
                end else begin
                    valid_d    = 1'b1;
                    ram_re     = pc_in_range;
                    hit_d      = pc_in_range;
                    addr_err_d = !pc_in_range;
                    redirect_d = !first_q && (PC != seq_pc);
                    last_pc_d  = PC;
                    first_d    = 1'b0;
                    if (pc_in_range && (fetch_count_q != COUNT_MAX)) begin
                        fetch_count_d = fetch_count_q + CW'(1);
                    end
                end
            end
            HALTED: begin
            end
            default: begin
                state_d = LOAD;
            end
        endcase

        running_d = (state_d == RUN);
    end

    // State and output registers; reset aborts load or run immediately.
    always_ff @(posedge CLK or posedge init) begin
        if (init) begin
            state_q       <= LOAD;
            valid_q       <= 1'b0;
            redirect_q    <= 1'b0;
            addr_err_q    <= 1'b0;
            running_q     <= 1'b0;
            hit_q         <= 1'b0;
            first_q       <= 1'b1;
            last_pc_q     <= '0;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            valid_q       <= valid_d;
            redirect_q    <= redirect_d;
            addr_err_q    <= addr_err_d;
            running_q     <= running_d;
            hit_q         <= hit_d;
            first_q       <= first_d;
            last_pc_q     <= last_pc_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    // The RAM read register has no reset, so the registered hit flag masks
    // it whenever no in-range fetch result is being presented.
    assign instruction = hit_q ? ram_rdata : IW'(NOP_INSTR);
    assign instr_valid = valid_q;
    assign redirect    = redirect_q;
    assign addr_err    = addr_err_q;
    assign running     = running_q;
    assign fetch_count = fetch_count_q;

endmodule
